// File: rtl/segment_uop_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : segment_uop_sequencer
// Purpose  : Splits one segmented vector load/store into per-element micro-ops
//            (segment-major) with a bounded number in flight.
// Revision : 1.0
// ============================================================================
module segment_uop_sequencer #(
   parameter int AddrWidth      = 64,
   parameter int VlWidth        = 16,
   parameter int MaxNf          = 8,
   parameter int MaxOutstanding = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 seg_valid_i,
   output logic                 seg_ready_o,
   input  logic                 seg_is_load_i,
   input  logic                 seg_unit_stride_i,
   input  logic [2:0]           seg_nf_i,
   input  logic [1:0]           seg_eew_i,
   input  logic [VlWidth-1:0]   seg_vl_i,
   input  logic [VlWidth-1:0]   seg_vstart_i,
   input  logic [AddrWidth-1:0] seg_base_i,
   input  logic [AddrWidth-1:0] seg_stride_i,
   input  logic [4:0]           seg_vd_i,
   output logic                 uop_valid_o,
   input  logic                 uop_ready_i,
   output logic [AddrWidth-1:0] uop_addr_o,
   output logic [4:0]           uop_vd_o,
   output logic [VlWidth-1:0]   uop_idx_o,
   output logic                 uop_is_load_o,
   input  logic                 uop_resp_valid_i,
   input  logic                 uop_resp_exc_i,
   output logic                 done_valid_o,
   input  logic                 done_ready_i,
   output logic                 done_exc_o,
   output logic [VlWidth-1:0]   done_vstart_o,
   output logic                 busy_o
);

   localparam int                   c_OUT_W   = $clog2(MaxOutstanding + 1);
   localparam logic [c_OUT_W-1:0]   c_MAX_OUT = c_OUT_W'(MaxOutstanding);
   localparam logic [2:0]           c_NF_MAX  = 3'(MaxNf - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                 r_state, w_state_nxt;
   logic                   r_is_load;
   logic [2:0]             r_nf;
   logic [1:0]             r_eew;
   logic [VlWidth-1:0]     r_vl;
   logic [AddrWidth-1:0]   r_base;
   logic [AddrWidth-1:0]   r_stride;
   logic [4:0]             r_vd;
   logic [VlWidth-1:0]     r_iseg, r_rseg;
   logic [2:0]             r_ifield, r_rfield;
   logic [c_OUT_W-1:0]     r_outst;
   logic                   r_exc;
   logic [VlWidth-1:0]     r_done_vstart;

   logic                   w_accept, w_uop_hs, w_resp, w_new_exc, w_last;
   logic [2:0]             w_nf;
   logic [AddrWidth-1:0]   w_stride;
   logic [c_OUT_W-1:0]     w_outst_nxt;

   assign w_accept    = seg_valid_i && seg_ready_o;
   assign w_nf        = ({1'b0, seg_nf_i} >= 4'(MaxNf)) ? c_NF_MAX : seg_nf_i;
   assign w_stride    = seg_unit_stride_i
                        ? (AddrWidth'({1'b0, w_nf} + 4'd1) << seg_eew_i)
                        : seg_stride_i;
   assign w_uop_hs    = uop_valid_o && uop_ready_i;
   // Responses with nothing in flight are stray and must not underflow.
   assign w_resp      = uop_resp_valid_i && (r_outst != '0);
   assign w_new_exc   = w_resp && uop_resp_exc_i && !r_exc;
   assign w_last      = (r_iseg == r_vl - VlWidth'(1)) && (r_ifield == r_nf);
   assign w_outst_nxt = r_outst + c_OUT_W'(w_uop_hs) - c_OUT_W'(w_resp);

   assign uop_addr_o    = r_base + (AddrWidth'(r_iseg) * r_stride)
                          + (AddrWidth'(r_ifield) << r_eew);
   assign uop_vd_o      = r_vd + {2'b00, r_ifield};
   assign uop_idx_o     = r_iseg;
   assign uop_is_load_o = r_is_load;
   assign busy_o        = (r_state != S_IDLE);
   assign done_exc_o    = (r_state == S_DONE) && r_exc;
   assign done_vstart_o = (r_state == S_DONE) ? r_done_vstart : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      seg_ready_o  = 1'b0;
      uop_valid_o  = 1'b0;
      done_valid_o = 1'b0;
      case (r_state)
         S_IDLE: begin
            seg_ready_o = 1'b1;
            if (w_accept) begin
               w_state_nxt = (seg_vl_i <= seg_vstart_i) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            uop_valid_o = (r_outst < c_MAX_OUT) && !r_exc;
            if (w_new_exc || (w_uop_hs && w_last)) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_outst_nxt == '0) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done_valid_o = 1'b1;
            if (done_ready_i) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         r_is_load     <= 1'b0;
         r_nf          <= '0;
         r_eew         <= '0;
         r_vl          <= '0;
         r_base        <= '0;
         r_stride      <= '0;
         r_vd          <= '0;
         r_iseg        <= '0;
         r_rseg        <= '0;
         r_ifield      <= '0;
         r_rfield      <= '0;
         r_outst       <= '0;
         r_exc         <= 1'b0;
         r_done_vstart <= '0;
      end else if (w_accept) begin
         r_is_load     <= seg_is_load_i;
         r_nf          <= w_nf;
         r_eew         <= seg_eew_i;
         r_vl          <= seg_vl_i;
         r_base        <= seg_base_i;
         r_stride      <= w_stride;
         r_vd          <= seg_vd_i;
         r_iseg        <= seg_vstart_i;
         r_rseg        <= seg_vstart_i;
         r_ifield      <= '0;
         r_rfield      <= '0;
         r_outst       <= '0;
         r_exc         <= 1'b0;
         r_done_vstart <= seg_vl_i;
      end else begin
         r_outst <= w_outst_nxt;
         if (w_uop_hs) begin
            if (r_ifield == r_nf) begin
               r_ifield <= '0;
               r_iseg   <= r_iseg + VlWidth'(1);
            end else begin
               r_ifield <= r_ifield + 3'd1;
            end
         end
         // The response pointer names the segment a faulting response belongs to.
         if (w_resp) begin
            if (r_rfield == r_nf) begin
               r_rfield <= '0;
               r_rseg   <= r_rseg + VlWidth'(1);
            end else begin
               r_rfield <= r_rfield + 3'd1;
            end
            if (w_new_exc) begin
               r_exc         <= 1'b1;
               r_done_vstart <= r_rseg;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/segment_uop_sequencer.md
Name: segment_uop_sequencer

Overview:
Parametrised next-generation segment sequencer. It accepts one segmented vector load/store (NF fields, unit-stride or strided) and breaks it into single-element memory micro-ops, in segment-major order, toward the VLSU. It keeps up to MaxOutstanding micro-ops in flight instead of serialising them. It tracks in-order micro-op responses, aborts on the first exception and reports that exception with the vstart of the faulting segment. It sits between the dispatcher front-end and the backend request/response path.

Parameters:
AddrWidth, 64, width of base address, stride and micro-op address
VlWidth, 16, width of vl/vstart/segment index
MaxNf, 8, maximum fields per segment (1..8); seg_nf_i is fields-1
MaxOutstanding, 4, maximum issued-but-unanswered micro-ops (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  synchronous abort of the current operation, no done response
seg_valid_i  in  1  segment request valid
seg_ready_o  out  1  request accepted when valid&ready
seg_is_load_i  in  1  1=load, 0=store
seg_unit_stride_i  in  1  1=unit-stride segment, stride derived internally
seg_nf_i  in  3  fields-1; values >= MaxNf are clamped to MaxNf-1
seg_eew_i  in  2  log2 element bytes
seg_vl_i  in  VlWidth  vector length
seg_vstart_i  in  VlWidth  first segment index
seg_base_i  in  AddrWidth  base address
seg_stride_i  in  AddrWidth  segment stride, used when seg_unit_stride_i=0
seg_vd_i  in  5  base vector register
uop_valid_o  out  1  micro-op valid
uop_ready_i  in  1  backend accepts micro-op
uop_addr_o  out  AddrWidth  element address
uop_vd_o  out  5  seg_vd_i+field, modulo 32
uop_idx_o  out  VlWidth  segment index; backend uses vstart=idx, vl=idx+1
uop_is_load_o  out  1  latched direction
uop_resp_valid_i  in  1  in-order response for the oldest outstanding micro-op
uop_resp_exc_i  in  1  response carries an exception
done_valid_o  out  1  operation complete
done_ready_i  in  1  consumer takes the completion
done_exc_o  out  1  operation ended by an exception
done_vstart_o  out  VlWidth  faulting segment index if done_exc_o, else vl
busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, all counters 0. seg_ready_o=1, uop_valid_o=0, done_valid_o=0, done_exc_o=0, done_vstart_o=0, busy_o=0.
- IDLE: seg_ready_o=1. On accept, latch all seg_* fields. Stride S = (nf+1)<<eew if unit-stride, else seg_stride_i. Issue pointer (seg=vstart, field=0), response pointer identical, outstanding=0, exc flag=0. If vl<=vstart, go to DONE; otherwise go to ISSUE. The first uop_valid_o appears on the cycle after accept.
- ISSUE: uop_valid_o=1 while outstanding<MaxOutstanding and exc flag=0.
  - uop_addr_o = base + seg*S + (field<<eew), all arithmetic truncated to AddrWidth.
  - On handshake: field++. If field==nf, field=0 and seg++.
  - After the handshake of the last micro-op (seg=vl-1, field=nf), go to DRAIN.
  - uop_* outputs are stable while uop_valid_o=1 and uop_ready_i=0.
- Outstanding counter: +1 on uop handshake, -1 on uop_resp_valid_i. On a simultaneous handshake and response the counter is unchanged. A response while outstanding=0 is ignored.
- Response pointer: advances in the same segment-major order on each response.
  - On the first response with uop_resp_exc_i=1: set exc flag, capture done_vstart = response segment, stop issuing, go to DRAIN.
  - Later responses only decrement the counter.
- DRAIN: uop_valid_o=0. Go to DONE when outstanding==0, including a final response arriving in the same cycle.
- DONE: done_valid_o=1, done_exc_o=exc flag, done_vstart_o = captured segment or vl. Hold until done_ready_i, then go to IDLE. seg_ready_o=0 in every state except IDLE.
- flush_i: in any state, go to IDLE next cycle and clear counters and outputs as on reset. flush_i has priority over all other events and produces no done response.
- rst_i mid-operation: same as flush_i.
- Throughput: with uop_ready_i=1, responses timely and MaxOutstanding>=response latency, one micro-op per cycle.

Test Plan:
- Unit-stride load: nf=2, eew=2, vl=2, vstart=0, base=0x1000, ready always 1, response 2 cycles after issue. Required: 6 uops, idx 0,0,0,1,1,1; vd +0,+1,+2; addresses 0x1000,0x1004,0x1008,0x100C,0x1010,0x1014. Then done_exc=0 and done_vstart=2.
- Strided store: stride 0x100, nf=1, eew=3, vstart=1, vl=3. Required: addresses base+0x100, +0x108, +0x200, +0x208.
- Backpressure: MaxOutstanding=2, responses withheld. Required: uop_valid_o drops after 2 handshakes; uop_* outputs stable under uop_ready_i=0.
- Exception: the 4th response (seg 1, nf=2) has exc=1 while 2 more micro-ops are outstanding. Required: no further issue; done appears only after both remaining responses; done_exc=1, done_vstart=1.
- Edge: vl=vstart=5. Required: zero uops; done_vstart=5 on the second cycle after accept. A second request is not accepted until done_ready_i.
- flush_i asserted mid-ISSUE with 3 outstanding. Required: next cycle busy_o=0, seg_ready_o=1, and no done_valid_o.
